// File: rtl/paddle_tracker_if.sv
// Ball-in / paddle-out bundle between the ball generator, the tracker and the renderer.
// PADDLE_TRACKER_SCORE_EN adds the saturating hits/misses score outputs.
interface paddle_tracker_if;
  logic        en;
  logic [10:0] ball_x;
  logic [10:0] ball_y;
  logic [10:0] paddle_y;
  logic        hit;
  logic        miss;
  logic [1:0]  state;
`ifdef PADDLE_TRACKER_SCORE_EN
  logic [7:0]  hits;
  logic [7:0]  misses;

  modport master (output en, ball_x, ball_y,
                  input  paddle_y, hit, miss, state, hits, misses);
  modport slave  (input  en, ball_x, ball_y,
                  output paddle_y, hit, miss, state, hits, misses);
`else
  modport master (output en, ball_x, ball_y,
                  input  paddle_y, hit, miss, state);
  modport slave  (input  en, ball_x, ball_y,
                  output paddle_y, hit, miss, state);
`endif
endinterface

// File: rtl/paddle_tracker.sv
// Computer paddle: tracks an approaching ball, recentres on a receding one, flags hit/miss.
// PADDLE_TRACKER_SCORE_EN adds saturating 8-bit hits/misses counters.
module paddle_tracker #(
  parameter int unsigned PADDLE_X = 600,
  parameter int unsigned PADDLE_H = 60,
  parameter int unsigned Y_MIN    = 30,
  parameter int unsigned Y_MAX    = 450,
  parameter int unsigned DEADZONE = 2,
  parameter int unsigned DIV_W    = 18
) (
  input  logic             clk,
  input  logic             rst,
  paddle_tracker_if.slave  bus
);

  localparam int unsigned CW = 11;
  localparam int unsigned WW = CW + 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_TRACK  = 2'd1;
  localparam logic [1:0] S_RETURN = 2'd2;

  localparam logic [WW-1:0] MID_Y   = WW'((Y_MIN + Y_MAX) / 2);
  localparam logic [WW-1:0] HALF_H  = WW'(PADDLE_H / 2);
  localparam logic [WW-1:0] DZ      = WW'(DEADZONE);
  localparam logic [WW-1:0] LAST_ROW = WW'(PADDLE_H - 1);
  localparam logic [WW-1:0] PY_LO   = WW'(Y_MIN);
  localparam logic [WW-1:0] PY_HI   = WW'(Y_MAX - PADDLE_H);
  localparam logic [CW-1:0] PY_RST  = CW'((Y_MIN + Y_MAX) / 2 - PADDLE_H / 2);
  localparam logic [CW-1:0] PX      = CW'(PADDLE_X);

  logic [DIV_W-1:0] div_q;
  logic             tick;

  logic [1:0]    state_q,  state_nxt;
  logic [CW-1:0] py_q,     py_nxt;
  logic [CW-1:0] prev_x_q, prev_x_nxt;
  logic [CW-1:0] prev_y_q, prev_y_nxt;
  logic          hit_q,    hit_nxt;
  logic          miss_q,   miss_nxt;

  logic [WW-1:0] centre, bottom, target, py_mv;
  logic          crossing;

  assign tick     = bus.en && (div_q == {DIV_W{1'b1}});
  assign centre   = {1'b0, py_q} + HALF_H;
  assign bottom   = {1'b0, py_q} + LAST_ROW;
  assign crossing = (prev_x_q < PX) && (bus.ball_x >= PX);

  // Tick divider; freezes while en is low
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) div_q <= '0;
    else if (bus.en) div_q <= div_q + DIV_W'(1);
  end

  // Next-state, paddle motion and crossing detection
  always_comb begin
    state_nxt  = state_q;
    py_nxt     = py_q;
    prev_x_nxt = prev_x_q;
    prev_y_nxt = prev_y_q;
    hit_nxt    = 1'b0;
    miss_nxt   = 1'b0;
    target     = MID_Y;
    py_mv      = {1'b0, py_q};

    if (tick) begin
      prev_x_nxt = bus.ball_x;
      prev_y_nxt = bus.ball_y;

      case (state_q)
        S_TRACK, S_RETURN: begin
          if (bus.ball_x > prev_x_q)      state_nxt = S_TRACK;
          else if (bus.ball_x < prev_x_q) state_nxt = S_RETURN;

          target = (state_nxt == S_TRACK) ? {1'b0, bus.ball_y} : MID_Y;

          if (target > centre + DZ)      py_mv = {1'b0, py_q} + WW'(1);
          else if (target + DZ < centre) py_mv = {1'b0, py_q} - WW'(1);

          if (py_mv > PY_HI)      py_nxt = CW'(PY_HI);
          else if (py_mv < PY_LO) py_nxt = CW'(PY_LO);
          else                    py_nxt = CW'(py_mv);

          // Hit window uses the paddle position before this tick's move
          if (crossing) begin
            if (({1'b0, bus.ball_y} >= {1'b0, py_q}) && ({1'b0, bus.ball_y} <= bottom))
              hit_nxt = 1'b1;
            else
              miss_nxt = 1'b1;
          end
        end
        default: state_nxt = S_RETURN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      py_q     <= PY_RST;
      prev_x_q <= '0;
      prev_y_q <= '0;
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      py_q     <= py_nxt;
      prev_x_q <= prev_x_nxt;
      prev_y_q <= prev_y_nxt;
      hit_q    <= hit_nxt;
      miss_q   <= miss_nxt;
    end
  end

  assign bus.paddle_y = py_q;
  assign bus.hit      = hit_q;
  assign bus.miss     = miss_q;
  assign bus.state    = state_q;

`ifdef PADDLE_TRACKER_SCORE_EN
  logic [7:0] hits_q, misses_q;

  // Score counters saturate at 255
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hits_q   <= '0;
      misses_q <= '0;
    end else begin
      if (hit_nxt && (hits_q != 8'hFF))    hits_q   <= hits_q + 8'd1;
      if (miss_nxt && (misses_q != 8'hFF)) misses_q <= misses_q + 8'd1;
    end
  end

  assign bus.hits   = hits_q;
  assign bus.misses = misses_q;
`endif

endmodule

// File: tb/tb_paddle_tracker.sv
// Directed bench for paddle_tracker with a 4-cycle tick (DIV_W=2).
// Score counter checks compile only with PADDLE_TRACKER_SCORE_EN.
module tb_paddle_tracker;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  paddle_tracker_if bus ();

  paddle_tracker #(.DIV_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present a ball position and run exactly one tick period (tick on the 4th edge)
  task automatic tick_step(input int x, input int y);
    bus.ball_x = 11'(x);
    bus.ball_y = 11'(y);
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Pulse reset; release just after an edge so the divider restarts aligned
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_py;
    int ret_py [6] = '{215, 214, 213, 212, 212, 212};

    bus.en     = 1'b1;
    bus.ball_x = '0;
    bus.ball_y = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_py",    32'(bus.paddle_y), 210);
    check("rst_state", 32'(bus.state), 0);
    check("rst_hit",   32'(bus.hit), 0);
    check("rst_miss",  32'(bus.miss), 0);
`ifdef PADDLE_TRACKER_SCORE_EN
    check("rst_hits",   32'(bus.hits), 0);
    check("rst_misses", 32'(bus.misses), 0);
`endif
    rst = 1'b1;

    // First tick is an IDLE capture: no movement
    bus.ball_x = 11'd100;
    bus.ball_y = 11'd445;
    repeat (3) @(posedge clk);
    #1;
    check("pre_tick_state", 32'(bus.state), 0);
    @(posedge clk); #1;
    check("cap_state", 32'(bus.state), 2);
    check("cap_py",    32'(bus.paddle_y), 210);

    // Track a low ball: climb one pixel per tick, clamp at 390
    for (int k = 1; k <= 185; k++) begin
      tick_step(100 + k, 445);
      exp_py = (210 + k > 390) ? 390 : 210 + k;
      check("track_py", 32'(bus.paddle_y), 32'(exp_py));
    end
    check("track_state", 32'(bus.state), 1);

    // Deadzone and return
    do_reset();
    tick_step(100, 242);
    check("dz_cap_state", 32'(bus.state), 2);
    tick_step(101, 242);
    check("dz_state", 32'(bus.state), 1);
    check("dz_hold",  32'(bus.paddle_y), 210);
    tick_step(102, 243);
    check("dz_edge",  32'(bus.paddle_y), 211);
    tick_step(103, 243);
    check("dz_hold2", 32'(bus.paddle_y), 211);
    for (int i = 0; i < 5; i++) tick_step(104 + i, 300);
    check("dz_climb", 32'(bus.paddle_y), 216);
    for (int i = 0; i < 6; i++) begin
      tick_step(107 - i, 300);
      check("ret_py", 32'(bus.paddle_y), 32'(ret_py[i]));
    end
    check("ret_state", 32'(bus.state), 2);

    // Hit across the paddle column
    do_reset();
    tick_step(598, 230);
    tick_step(599, 230);
    check("pre_hit_py",  32'(bus.paddle_y), 209);
    check("pre_hit_hit", 32'(bus.hit), 0);
    tick_step(600, 230);
    check("hit_hit",  32'(bus.hit), 1);
    check("hit_miss", 32'(bus.miss), 0);
    check("hit_py",   32'(bus.paddle_y), 208);
    bus.ball_x = 11'd601;
    @(posedge clk); #1;
    check("hit_width", 32'(bus.hit), 0);
    repeat (3) @(posedge clk);
    #1;
    check("no_rehit",  32'(bus.hit), 0);
    check("no_remiss", 32'(bus.miss), 0);
    check("post_hit_py", 32'(bus.paddle_y), 207);

    // Miss below the paddle
    tick_step(590, 300);
    check("recede_state", 32'(bus.state), 2);
    check("recede_py",    32'(bus.paddle_y), 208);
    tick_step(599, 300);
    check("appr_py", 32'(bus.paddle_y), 209);
    tick_step(600, 300);
    check("miss_miss", 32'(bus.miss), 1);
    check("miss_hit",  32'(bus.hit), 0);
    check("miss_py",   32'(bus.paddle_y), 210);

    // Freeze with en low, then resume mid-period
    bus.en = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("frz_miss",  32'(bus.miss), 0);
    check("frz_py",    32'(bus.paddle_y), 210);
    check("frz_state", 32'(bus.state), 1);
    bus.en     = 1'b1;
    bus.ball_x = 11'd601;
    repeat (3) @(posedge clk);
    #1;
    check("resume_early", 32'(bus.paddle_y), 210);
    @(posedge clk); #1;
    check("resume_tick",  32'(bus.paddle_y), 211);

    // Climb to 301, then recede one tick to reach 300 in RETURN
    for (int k = 0; k < 90; k++) tick_step(602 + k, 445);
    check("climb_py", 32'(bus.paddle_y), 301);
    tick_step(690, 445);
    check("mid_state", 32'(bus.state), 2);
    check("mid_py",    32'(bus.paddle_y), 300);

    // Asynchronous reset between edges
    #2;
    rst = 1'b0;
    #1;
    check("async_py",    32'(bus.paddle_y), 210);
    check("async_state", 32'(bus.state), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    tick_step(100, 240);
    check("rel_cap_state", 32'(bus.state), 2);
    check("rel_cap_py",    32'(bus.paddle_y), 210);
    tick_step(101, 240);
    check("rel_track_state", 32'(bus.state), 1);
    check("rel_track_py",    32'(bus.paddle_y), 210);

`ifdef PADDLE_TRACKER_SCORE_EN
    // 260 crossings at paddle centre; hits saturate
    for (int n = 0; n < 260; n++) begin
      tick_step(599, 240);
      tick_step(600, 240);
    end
    check("hits_sat",   32'(bus.hits), 255);
    check("misses_sat", 32'(bus.misses), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
